// File: rtl/vtx_mem_txn_recorder.sv
// ============================================================================
//  vtx_mem_txn_recorder : per-instruction memory transaction recorder
//  Rev 1.0 - parametrised slot depth, in-order response matching, snapshots
// ============================================================================
`default_nettype none

module vtx_mem_txn_recorder #(
  parameter int NTXN   = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MAXOUT = 2
) (
  input  logic                   vtx_clk,
  input  logic                   vtx_resetn,
  input  logic                   mem_cen,
  input  logic                   mem_gnt,
  input  logic                   mem_wen,
  input  logic [AW-1:0]          mem_addr,
  input  logic [DW-1:0]          mem_wdata,
  input  logic [DW/8-1:0]        mem_ben,
  input  logic                   mem_rsp_valid,
  input  logic [DW-1:0]          mem_rdata,
  input  logic                   mem_error,
  input  logic                   instr_retire,
  output logic                   vtx_valid,
  output logic [$clog2(NTXN+1)-1:0] vtx_txn_count,
  output logic                   vtx_overflow,
  output logic                   vtx_incomplete,
  output logic                   vtx_proto_err,
  output logic [NTXN-1:0]        vtx_mem_cen,
  output logic [NTXN-1:0]        vtx_mem_wen,
  output logic [NTXN*AW-1:0]     vtx_mem_addr,
  output logic [NTXN*DW-1:0]     vtx_mem_wdata,
  output logic [NTXN*DW-1:0]     vtx_mem_rdata,
  output logic [NTXN*DW/8-1:0]   vtx_mem_ben,
  output logic [NTXN-1:0]        vtx_mem_error
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(NTXN + 1);
  // One extra bit so req_idx can keep counting past NTXN before saturating.
  localparam int IW = CW + 1;
  localparam int OW = IW + 1;
  localparam logic [IW-1:0] NTXN_I   = IW'(NTXN);
  localparam logic [IW-1:0] IDX_MAX  = {IW{1'b1}};
  localparam logic [OW-1:0] MAXOUT_O = OW'(MAXOUT);

  // Live record state
  logic [IW-1:0]      req_idx_q, req_idx_d, rsp_idx_q, rsp_idx_d, stale_q, stale_d;
  logic               ovf_q, ovf_d, perr_q, perr_d;
  logic [NTXN-1:0]    slot_cen_q, slot_cen_d, slot_wen_q, slot_wen_d, slot_err_q, slot_err_d;
  logic [NTXN*AW-1:0] slot_addr_q, slot_addr_d;
  logic [NTXN*DW-1:0] slot_wdata_q, slot_wdata_d, slot_rdata_q, slot_rdata_d;
  logic [NTXN*BW-1:0] slot_ben_q, slot_ben_d;

  // Snapshot state
  logic               snap_valid_q, snap_valid_d, snap_ovf_q, snap_ovf_d, snap_inc_q, snap_inc_d;
  logic [CW-1:0]      snap_count_q, snap_count_d;
  logic [NTXN-1:0]    snap_cen_q, snap_cen_d, snap_wen_q, snap_wen_d, snap_err_q, snap_err_d;
  logic [NTXN*AW-1:0] snap_addr_q, snap_addr_d;
  logic [NTXN*DW-1:0] snap_wdata_q, snap_wdata_d, snap_rdata_q, snap_rdata_d;
  logic [NTXN*BW-1:0] snap_ben_q, snap_ben_d;

  // Combinational helpers
  logic               accept, rsp_stale, rsp_match, rsp_orphan, req_at_max, wr_en;
  logic [IW-1:0]      rsp_idx_a, stale_a, pending, wr_idx, stale_ret;
  logic [OW-1:0]      outstanding, stale_sum;
  logic [NTXN*DW-1:0] rdata_m;
  logic [NTXN-1:0]    err_m;

  always_comb begin
    accept      = mem_cen & mem_gnt;
    rsp_stale   = mem_rsp_valid && (stale_q != '0);
    rsp_match   = mem_rsp_valid && (stale_q == '0) && (rsp_idx_q < req_idx_q);
    rsp_orphan  = mem_rsp_valid && (stale_q == '0) && !(rsp_idx_q < req_idx_q);
    outstanding = OW'(req_idx_q - rsp_idx_q) + OW'(stale_q);
    req_at_max  = accept && (outstanding >= MAXOUT_O);

    // Current record with this cycle's response merged in
    rdata_m = slot_rdata_q;
    err_m   = slot_err_q;
    for (int i = 0; i < NTXN; i++) begin
      if (rsp_match && (rsp_idx_q == IW'(i))) begin
        rdata_m[i*DW +: DW] = mem_rdata;
        err_m[i]            = mem_error;
      end
    end
    rsp_idx_a = rsp_idx_q + IW'(rsp_match);
    stale_a   = stale_q - IW'(rsp_stale);
    pending   = req_idx_q - rsp_idx_a;
    stale_sum = OW'(stale_a) + OW'(pending);
    stale_ret = (stale_sum > OW'(IDX_MAX)) ? IDX_MAX : stale_sum[IW-1:0];

    // A request in a retire cycle opens the next record at slot 0
    wr_en  = accept && (instr_retire || (req_idx_q < NTXN_I));
    wr_idx = instr_retire ? '0 : req_idx_q;
  end

  always_comb begin
    req_idx_d    = req_idx_q;
    rsp_idx_d    = rsp_idx_a;
    stale_d      = stale_a;
    ovf_d        = ovf_q;
    perr_d       = perr_q | rsp_orphan | req_at_max;
    slot_cen_d   = slot_cen_q;
    slot_wen_d   = slot_wen_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_ben_d   = slot_ben_q;
    slot_rdata_d = rdata_m;
    slot_err_d   = err_m;
    snap_valid_d = 1'b0;
    snap_count_d = snap_count_q;
    snap_ovf_d   = snap_ovf_q;
    snap_inc_d   = snap_inc_q;
    snap_cen_d   = snap_cen_q;
    snap_wen_d   = snap_wen_q;
    snap_addr_d  = snap_addr_q;
    snap_wdata_d = snap_wdata_q;
    snap_ben_d   = snap_ben_q;
    snap_rdata_d = snap_rdata_q;
    snap_err_d   = snap_err_q;

    if (instr_retire) begin
      snap_valid_d = 1'b1;
      snap_count_d = (req_idx_q > NTXN_I) ? CW'(NTXN) : req_idx_q[CW-1:0];
      snap_ovf_d   = ovf_q;
      snap_inc_d   = (req_idx_q != rsp_idx_a);
      snap_cen_d   = slot_cen_q;
      snap_wen_d   = slot_wen_q;
      snap_addr_d  = slot_addr_q;
      snap_wdata_d = slot_wdata_q;
      snap_ben_d   = slot_ben_q;
      snap_rdata_d = rdata_m;
      snap_err_d   = err_m;

      // Responses still owed to this instruction become stale
      stale_d      = stale_ret;
      rsp_idx_d    = '0;
      req_idx_d    = accept ? IW'(1) : '0;
      ovf_d        = 1'b0;
      slot_cen_d   = '0;
      slot_wen_d   = '0;
      slot_addr_d  = '0;
      slot_wdata_d = '0;
      slot_ben_d   = '0;
      slot_rdata_d = '0;
      slot_err_d   = '0;
    end else if (accept) begin
      if (!(req_idx_q < NTXN_I)) ovf_d = 1'b1;
      req_idx_d = (req_idx_q == IDX_MAX) ? req_idx_q : req_idx_q + IW'(1);
    end

    for (int i = 0; i < NTXN; i++) begin
      if (wr_en && (wr_idx == IW'(i))) begin
        slot_cen_d[i]            = 1'b1;
        slot_wen_d[i]            = mem_wen;
        slot_addr_d[i*AW +: AW]  = mem_addr;
        slot_wdata_d[i*DW +: DW] = mem_wdata;
        slot_ben_d[i*BW +: BW]   = mem_ben;
      end
    end
  end

  always_ff @(posedge vtx_clk or negedge vtx_resetn) begin
    if (!vtx_resetn) begin
      req_idx_q    <= '0;
      rsp_idx_q    <= '0;
      stale_q      <= '0;
      ovf_q        <= 1'b0;
      perr_q       <= 1'b0;
      slot_cen_q   <= '0;
      slot_wen_q   <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_ben_q   <= '0;
      slot_rdata_q <= '0;
      slot_err_q   <= '0;
      snap_valid_q <= 1'b0;
      snap_count_q <= '0;
      snap_ovf_q   <= 1'b0;
      snap_inc_q   <= 1'b0;
      snap_cen_q   <= '0;
      snap_wen_q   <= '0;
      snap_addr_q  <= '0;
      snap_wdata_q <= '0;
      snap_ben_q   <= '0;
      snap_rdata_q <= '0;
      snap_err_q   <= '0;
    end else begin
      req_idx_q    <= req_idx_d;
      rsp_idx_q    <= rsp_idx_d;
      stale_q      <= stale_d;
      ovf_q        <= ovf_d;
      perr_q       <= perr_d;
      slot_cen_q   <= slot_cen_d;
      slot_wen_q   <= slot_wen_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_ben_q   <= slot_ben_d;
      slot_rdata_q <= slot_rdata_d;
      slot_err_q   <= slot_err_d;
      snap_valid_q <= snap_valid_d;
      snap_count_q <= snap_count_d;
      snap_ovf_q   <= snap_ovf_d;
      snap_inc_q   <= snap_inc_d;
      snap_cen_q   <= snap_cen_d;
      snap_wen_q   <= snap_wen_d;
      snap_addr_q  <= snap_addr_d;
      snap_wdata_q <= snap_wdata_d;
      snap_ben_q   <= snap_ben_d;
      snap_rdata_q <= snap_rdata_d;
      snap_err_q   <= snap_err_d;
    end
  end

  assign vtx_valid      = snap_valid_q;
  assign vtx_txn_count  = snap_count_q;
  assign vtx_overflow   = snap_ovf_q;
  assign vtx_incomplete = snap_inc_q;
  assign vtx_proto_err  = perr_q;
  assign vtx_mem_cen    = snap_cen_q;
  assign vtx_mem_wen    = snap_wen_q;
  assign vtx_mem_addr   = snap_addr_q;
  assign vtx_mem_wdata  = snap_wdata_q;
  assign vtx_mem_rdata  = snap_rdata_q;
  assign vtx_mem_ben    = snap_ben_q;
  assign vtx_mem_error  = snap_err_q;

endmodule

`default_nettype wire

// File: doc/vtx_mem_txn_recorder.md
Name: vtx_mem_txn_recorder

Overview:
- Per-instruction memory transaction recorder for the formal/verification environment.
- Monitors the core's split-phase data memory bus and records up to NTXN in-order transactions per retired instruction, including each transaction's response data and error.
- On each instruction retire it presents one snapshot: flattened per-slot buses, a transaction count and status flags.
- This generalises the fixed four-transaction checker interface to a parametrised depth, adds pipelined response matching, and handles overflow, stale responses and protocol errors.

Parameters:
- NTXN, 4: transaction slots recorded per instruction; minimum 1.
- AW, 32: address width.
- DW, 32: data width; must be a multiple of 8.
- MAXOUT, 2: maximum responses outstanding on the bus.

Ports:
- vtx_clk, input, 1: sole clock; all state updates on the rising edge.
- vtx_resetn, input, 1: asynchronous, active-low reset.
- mem_cen, input, 1: request valid.
- mem_gnt, input, 1: bus grant. A request is accepted when mem_cen & mem_gnt.
- mem_wen, input, 1: write request.
- mem_addr, input, AW: request address.
- mem_wdata, input, DW: write data.
- mem_ben, input, DW/8: byte enables.
- mem_rsp_valid, input, 1: response strobe; responses return in request order.
- mem_rdata, input, DW: response read data.
- mem_error, input, 1: response bus error.
- instr_retire, input, 1: single-cycle pulse when an instruction retires.
- vtx_valid, output, 1: snapshot valid, one cycle.
- vtx_txn_count, output, $clog2(NTXN+1): number of recorded slots.
- vtx_overflow, output, 1: more than NTXN requests were accepted.
- vtx_incomplete, output, 1: responses were still outstanding at retire.
- vtx_proto_err, output, 1: sticky protocol violation.
- vtx_mem_cen, output, NTXN: per-slot valid.
- vtx_mem_wen, output, NTXN: per-slot write flag.
- vtx_mem_addr, output, NTXN*AW: per-slot address; slot i occupies bits [i*AW +: AW].
- vtx_mem_wdata, output, NTXN*DW: per-slot write data.
- vtx_mem_rdata, output, NTXN*DW: per-slot response read data.
- vtx_mem_ben, output, NTXN*DW/8: per-slot byte enables.
- vtx_mem_error, output, NTXN: per-slot response error.

Behaviour:
- Reset (asynchronous, vtx_resetn=0):
  - All outputs 0.
  - Slot storage cleared.
  - Counters req_idx, rsp_idx and stale cleared to 0.
  - Reset asserted mid-instruction discards the partial record; no snapshot is produced.
- Request capture:
  - On accept with req_idx<NTXN, slot[req_idx] stores {cen=1, wen, addr, wdata, ben}, and req_idx increments.
  - On accept with req_idx>=NTXN, the request is not stored, the overflow flag sets, and req_idx keeps counting with saturation at its counter maximum.
- Response capture:
  - When mem_rsp_valid=1 and stale>0, the response belongs to an already-retired instruction: stale decrements and nothing is stored.
  - Otherwise, if rsp_idx<req_idx: when rsp_idx<NTXN, slot[rsp_idx] stores rdata and error; rsp_idx increments in either case.
  - A response with stale=0 and rsp_idx==req_idx sets vtx_proto_err (sticky until reset) and is ignored.
  - Outstanding count is req_idx-rsp_idx+stale. An accept while this count equals MAXOUT sets vtx_proto_err; the request is still recorded.
- Retire (instr_retire=1 at edge N):
  - A response in cycle N is applied to the current record before the snapshot.
  - A request accepted in cycle N belongs to the next instruction: it is written to slot 0 of the fresh record with req_idx=1.
  - Snapshot registers load at edge N and vtx_valid=1 during cycle N+1 only.
  - vtx_txn_count = min(req_idx,NTXN).
  - vtx_overflow = overflow flag.
  - vtx_incomplete = (req_idx>rsp_idx after this cycle's response).
  - Unfilled slots and unreturned rdata/error fields output 0.
  - After the snapshot: stale += (req_idx-rsp_idx), req_idx=rsp_idx=0 (or req_idx=1 per the same-cycle rule above), and overflow and slots clear.
- Snapshot outputs hold their values after vtx_valid drops, until the next retire.
- Back-to-back retires in consecutive cycles each produce a snapshot; an instruction with no transactions gives count 0.
- Latency: snapshot visible exactly 1 cycle after the retire pulse.

Test Plan:
- Load at 0x100, rsp rdata=0xDEADBEEF in the next cycle, retire 2 cycles later -> vtx_valid for 1 cycle, count=1, cen=0001, addr slot0=0x100, rdata slot0=0xDEADBEEF, incomplete=0.
- NTXN=4: six writes accepted, all responded, then retire -> count=4, overflow=1, slots hold the first four addresses, proto_err=0.
- Two requests accepted, one response, retire, then the second response arrives -> incomplete=1, slot1 rdata=0, stale response dropped, next instruction's slot0 unaffected.
- Request accepted in the same cycle as retire -> snapshot excludes it; the next snapshot has count=1 with that address.
- mem_rsp_valid with nothing outstanding, and a third accept with MAXOUT=2 outstanding -> vtx_proto_err=1 and it stays set.
- vtx_resetn pulsed low mid-instruction with 2 slots filled -> all outputs 0 immediately, a retire after reset reports count=0.
